mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Port list; one clock; reset is synchronous and active-low:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- ifreq  in  1  fetch request, held until ifdone
- ifaddr  in  32  fetch address
- ifrdata  out  32  fetched instruction
- ifdone  out  1  fetch complete, 1-cycle pulse
- dreq  in  1  MEM-stage load/store request, held until ddone
- dwe  in  1  store when 1
- daddr  in  32  data address
- dwdata  in  32  store data
- drdata  out  32  load data
- ddone  out  1  data access complete, 1-cycle pulse
- memreq  out  1  shared memory port request
- memwe  out  1  shared port write enable
- memaddr  out  32  shared port address
- memwdata  out  32  shared port write data
- memrdata  in  32  shared port read data, valid with memready
- memready  in  1  shared port access complete
- stallI  out  1  to hazard unit: fetch waiting
- stallM  out  1  to hazard unit: data access waiting

Function
REQ-002 FSM states IDLE, IFETCH, DACCESS; memreq SHALL be 1 exactly in IFETCH and DACCESS.
REQ-003 In IDLE, grant decision: dreq wins over ifreq, except when starve count equals STARVE_LIMIT (3) and ifreq is 1, then ifreq wins.
REQ-004 On grant, next state is IFETCH or DACCESS; memaddr, memwe, memwdata registered from the winner's inputs (memwe=0, memwdata=0 for fetch) and held stable until the state leaves.
REQ-005 With no request in IDLE, state remains IDLE and memaddr/memwe/memwdata hold their previous values.
REQ-006 In IFETCH with memready=1: ifdone=1 and ifrdata=memrdata combinationally in that cycle; next state IDLE.
REQ-007 In DACCESS with memready=1: ddone=1 and drdata=memrdata (memrdata ignored on stores, drdata=0); next state IDLE.
REQ-008 ifrdata/drdata SHALL be 0 whenever the matching done is 0.
REQ-009 memready is ignored in IDLE.
REQ-010 Minimum latency: request seen in IDLE in cycle N, memreq in N+1, done in N+1 if memready=1; wait states extend arbitrarily.
REQ-011 stallI = ifreq & ~ifdone; stallM = dreq & ~ddone; both combinational.
REQ-012 Starve counter (2 bits, saturating at 3): +1 on a data grant while ifreq=1; cleared on any fetch grant; unchanged otherwise.
REQ-013 A requester dropping its request mid-access SHALL NOT abort the access; its done still pulses.
REQ-014 dreq and ifreq both newly asserted on the cycle a done pulses SHALL be arbitrated in the following IDLE cycle, never in the done cycle.

Reset
REQ-015 reset_n=0 at a clock edge: state IDLE, starve counter 0, memaddr/memwe/memwdata 0; memreq, ifdone, ddone 0 from the next cycle.
REQ-016 Reset during IFETCH/DACCESS abandons the access; no done pulse is generated for it.

Structure
REQ-017 The FSM state enum (arb_state_t) and STARVE_LIMIT SHALL live in the shared mips_pkg package.
REQ-018 Single flat module; no sub-module; stallI/stallM feed the hazard unit's stall/flush logic unchanged.

Verification
REQ-019 Fetch only: ifreq=1, ifaddr=0x00000040, memready after 2 wait cycles, memrdata=0x20080005 -> memaddr=0x40, memwe=0, ifdone one cycle with ifrdata=0x20080005, stallI=1 until then.
REQ-020 Collision: ifreq=1, dreq=1, dwe=1, daddr=0x100, dwdata=0xDEADBEEF in the same IDLE cycle -> data granted first (memwe=1, memwdata=0xDEADBEEF), ddone, then fetch granted; stallI=1 throughout.
REQ-021 Starvation: dreq and ifreq held high, memready=1 every cycle -> three data grants, then fetch grant; counter back to 0.
REQ-022 Reset mid-access: reset_n=0 during DACCESS with memready=0 -> memreq=0 next cycle, no ddone, state IDLE.
REQ-023 Zero-wait back-to-back fetches: memready=1 constant, ifaddr 0x0, 0x4, 0x8 -> ifdone every second cycle, memaddr sequence 0x0, 0x4, 0x8.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory-side blocks: arbiter state encoding,
// fetch starvation limit and the grant decision helpers.
package mips_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IFETCH  = 2'd1,
    ARB_DACCESS = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_FETCH = 2'd1,
    GRANT_DATA  = 2'd2
  } grant_t;

  localparam logic [1:0] STARVE_LIMIT = 2'd3;

  // Data side normally wins; a fetch that has lost STARVE_LIMIT times in a row wins instead.
  function automatic grant_t arb_grant(input logic ifreq, input logic dreq,
                                       input logic [1:0] starve);
    grant_t g;
    if (ifreq && (!dreq || (starve == STARVE_LIMIT))) begin
      g = GRANT_FETCH;
    end else if (dreq) begin
      g = GRANT_DATA;
    end else begin
      g = GRANT_NONE;
    end
    return g;
  endfunction

  function automatic logic [1:0] starve_inc(input logic [1:0] cnt);
    logic [1:0] r;
    if (cnt == STARVE_LIMIT) begin
      r = cnt;
    end else begin
      r = cnt + 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the MEM-stage data
// access, with data priority and a fetch starvation guard.
module mem_arbiter
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ifreq,
  input  logic [31:0] ifaddr,
  output logic [31:0] ifrdata,
  output logic        ifdone,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        ddone,
  output logic        memreq,
  output logic        memwe,
  output logic [31:0] memaddr,
  output logic [31:0] memwdata,
  input  logic [31:0] memrdata,
  input  logic        memready,
  output logic        stallI,
  output logic        stallM
);

  arb_state_t state;
  arb_state_t state_next;
  grant_t     grant;
  logic [1:0] starve;

  // Arbitration happens only in IDLE, so a done cycle never grants.
  always_comb begin
    grant = GRANT_NONE;
    if (state == ARB_IDLE) begin
      grant = arb_grant(ifreq, dreq, starve);
    end else begin
      grant = GRANT_NONE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        case (grant)
          GRANT_FETCH: state_next = ARB_IFETCH;
          GRANT_DATA:  state_next = ARB_DACCESS;
          default:     state_next = ARB_IDLE;
        endcase
      end
      ARB_IFETCH, ARB_DACCESS: begin
        if (memready) begin
          state_next = ARB_IDLE;
        end else begin
          state_next = state;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Output logic; done is suppressed in a reset cycle so an abandoned access never completes.
  always_comb begin
    memreq  = 1'b0;
    ifdone  = 1'b0;
    ddone   = 1'b0;
    ifrdata = 32'd0;
    drdata  = 32'd0;
    case (state)
      ARB_IFETCH: begin
        memreq = 1'b1;
        if (memready && reset_n) begin
          ifdone  = 1'b1;
          ifrdata = memrdata;
        end else begin
          ifdone  = 1'b0;
          ifrdata = 32'd0;
        end
      end
      ARB_DACCESS: begin
        memreq = 1'b1;
        if (memready && reset_n) begin
          ddone = 1'b1;
          if (!memwe) begin
            drdata = memrdata;
          end else begin
            drdata = 32'd0;
          end
        end else begin
          ddone  = 1'b0;
          drdata = 32'd0;
        end
      end
      default: begin
        memreq  = 1'b0;
        ifdone  = 1'b0;
        ddone   = 1'b0;
        ifrdata = 32'd0;
        drdata  = 32'd0;
      end
    endcase
  end

  // Hazard-unit stalls.
  always_comb begin
    stallI = ifreq & ~ifdone;
    stallM = dreq & ~ddone;
  end

  // Shared-port command registers, captured at grant and held until the next grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      memaddr  <= 32'd0;
      memwe    <= 1'b0;
      memwdata <= 32'd0;
    end else begin
      case (grant)
        GRANT_FETCH: begin
          memaddr  <= ifaddr;
          memwe    <= 1'b0;
          memwdata <= 32'd0;
        end
        GRANT_DATA: begin
          memaddr  <= daddr;
          memwe    <= dwe;
          memwdata <= dwdata;
        end
        default: begin
          memaddr  <= memaddr;
          memwe    <= memwe;
          memwdata <= memwdata;
        end
      endcase
    end
  end

  // Starvation counter: counts data grants that made a waiting fetch lose.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve <= 2'd0;
    end else begin
      case (grant)
        GRANT_FETCH: starve <= 2'd0;
        GRANT_DATA: begin
          if (ifreq) begin
            starve <= starve_inc(starve);
          end else begin
            starve <= starve;
          end
        end
        default: starve <= starve;
      endcase
    end
  end

endmodule
